// File: rtl/gp_div_unit_if.sv
// Operand/result bundle between the GP register file stages and the divider.
interface gp_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_idx;
  logic        kill;
  logic        busy;
  logic        result_valid;
  logic [4:0]  result_idx;
  logic [31:0] result_data;

  modport master (
    output start, op, operand_a, operand_b, rd_idx, kill,
    input  busy, result_valid, result_idx, result_data
  );

  modport slave (
    input  start, op, operand_a, operand_b, rd_idx, kill,
    output busy, result_valid, result_idx, result_data
  );
endinterface

// File: rtl/gp_div_unit.sv
// RV32M DIV/DIVU/REM/REMU: radix-2 restoring divider, one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module gp_div_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  gp_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [1:0]        op_q;
  logic [4:0]        idx_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic              valid_q;
  logic [4:0]        res_idx_q;
  logic [XLEN-1:0]   res_data_q;

  logic              is_signed, a_neg, b_neg, b_zero, ovf, fast;
  logic [XLEN-1:0]   a_mag, b_mag, fast_data;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_d, quo_d, q_fix, r_fix;

  // op[1] selects remainder, op[0] selects unsigned
  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.operand_a[XLEN-1];
    b_neg     = is_signed & bus.operand_b[XLEN-1];
    a_mag     = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag     = b_neg ? -bus.operand_b : bus.operand_b;
    b_zero    = (bus.operand_b == '0);
    ovf       = is_signed && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                          && (bus.operand_b == '1);
    fast      = b_zero | ovf;
    if (b_zero) fast_data = bus.op[1] ? bus.operand_a : '1;
    else        fast_data = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

    // rem < divisor always holds, so the difference never needs a 34th bit
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, div_q};
    if (!diff[XLEN]) begin
      rem_d = diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
    q_fix = neg_q_q ? -quo_d : quo_d;
    r_fix = neg_r_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      valid_q    <= 1'b0;
      res_idx_q  <= '0;
      res_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start && !bus.kill) begin
            op_q    <= bus.op;
            idx_q   <= bus.rd_idx;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            div_q   <= b_mag;
            if (fast) begin
              res_data_q <= fast_data;
              res_idx_q  <= bus.rd_idx;
              valid_q    <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= a_mag;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.kill) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              res_data_q <= op_q[1] ? r_fix : q_fix;
              res_idx_q  <= idx_q;
              valid_q    <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = valid_q;
  assign bus.result_idx   = res_idx_q;
  assign bus.result_data  = res_data_q;

endmodule

// File: tb/tb_gp_div_unit.sv
// Self-checking bench for gp_div_unit: directed RV32M cases, randomized ops
// against an arithmetic reference, busy/kill/reset corner cases.
module tb_gp_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   vcount = 0;
  logic [31:0] last_data = '0;
  logic [4:0]  last_idx  = '0;

  gp_div_unit_if bus ();

  gp_div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.result_valid) vcount <= vcount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_result = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.rd_idx = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.rd_idx = 5'($urandom); bus.op = 2'($urandom);
  endtask

  // Called #1 after the accepting edge; lat = number of edges from start to visible valid
  task automatic wait_result(input int t0, output int lat);
    lat = cyc - t0 + 1;
    while (!bus.result_valid && lat < 45) begin
      @(posedge clk); #1;
      lat = cyc - t0 + 1;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int t0, lat;
    logic [31:0] ed;
    ed = ref_result(op, a, b);
    drive_start(op, a, b, rd);
    t0 = cyc;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    wait_result(t0, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
    chk({tag, ".data"}, bus.result_data, ed);
    chk({tag, ".idx"}, 32'(bus.result_idx), 32'(rd));
    last_data = ed;
    last_idx  = rd;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(bus.result_valid), 32'd0);
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t0, lat, v0;
    logic [1:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.rd_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.busy",  32'(bus.busy), 32'd0);
    chk("rst.valid", 32'(bus.result_valid), 32'd0);
    chk("rst.data",  bus.result_data, 32'd0);
    chk("rst.idx",   32'(bus.result_idx), 32'd0);

    run_op("div100_7",  2'b00, 32'd100, 32'd7, 5'd5);
    run_op("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op("divu_max",  2'b01, 32'hFFFF_FFFF, 32'd1, 5'd4);
    run_op("remu_16",   2'b11, 32'hFFFF_FFFF, 32'h10, 5'd6);
    run_op("div_by0",   2'b00, 32'h1234_5678, 32'd0, 5'd7);
    run_op("remu_by0",  2'b11, 32'h1234_5678, 32'd0, 5'd8);
    run_op("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op("divu_nf",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op("div_rd0",   2'b00, 32'hFFFF_FF9C, 32'd7, 5'd0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, 5'($urandom));
    end

    // second start while busy is ignored
    v0 = vcount;
    drive_start(2'b00, 32'd100, 32'd7, 5'd5);
    t0 = cyc;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd50; bus.operand_b = 32'd3; bus.rd_idx = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_result(t0, lat);
    chk("busy_start.lat",  32'(lat), 32'd33);
    chk("busy_start.data", bus.result_data, 32'd14);
    chk("busy_start.idx",  32'(bus.result_idx), 32'd5);
    last_data = 32'd14; last_idx = 5'd5;
    repeat (40) @(posedge clk); #1;
    chk("busy_start.pulses", 32'(vcount - v0), 32'd1);

    // kill in RUN
    v0 = vcount;
    drive_start(2'b01, 32'd1000, 32'd3, 5'd9);
    repeat (14) @(posedge clk);
    @(negedge clk) bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    chk("kill.busy",  32'(bus.busy), 32'd0);
    chk("kill.valid", 32'(bus.result_valid), 32'd0);
    chk("kill.data",  bus.result_data, last_data);
    chk("kill.idx",   32'(bus.result_idx), 32'(last_idx));
    run_op("after_kill", 2'b01, 32'd1000, 32'd3, 5'd9);
    chk("kill.pulses", 32'(vcount - v0), 32'd1);

    // kill in IDLE blocks a simultaneous start
    v0 = vcount;
    @(negedge clk);
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("idle_kill.busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("idle_kill.pulses", 32'(vcount - v0), 32'd0);

    // asynchronous reset mid-division
    drive_start(2'b00, 32'd100, 32'd7, 5'd5);
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst.busy",  32'(bus.busy), 32'd0);
    chk("arst.valid", 32'(bus.result_valid), 32'd0);
    chk("arst.data",  bus.result_data, 32'd0);
    chk("arst.idx",   32'(bus.result_idx), 32'd0);
    @(negedge clk) rst = 1'b0;
    v0 = vcount;
    repeat (40) @(posedge clk); #1;
    chk("arst.pulses", 32'(vcount - v0), 32'd0);
    chk("arst.idle",   32'(bus.busy), 32'd0);
    run_op("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
